mouse_transmitter: RTL and testbench

Host-to-device PS/2 byte transmitter for the mouse interface: sends one command byte (e.g. 0xFF reset, 0xF4 enable reporting) to the mouse using the PS/2 host request-to-send sequence, then checks the device acknowledge. It sits beside the mouse receiver under the mouse master state machine and shares the same open-drain clock and data lines. It drives each line only through an output-enable, with an external pull-up.

---
 rtl/mouse_transmitter.sv | 218 +++++++++++++++++++++
 tb/tb_mouse_transmitter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device byte transmitter. Performs the host request-to-send
// sequence (clock held low, start bit, clock release), shifts out eight data
// bits LSB first plus odd parity on device falling edges, releases data for
// the stop bit, then checks the device acknowledge and waits for bus idle.
// Both PS/2 lines are driven only through output enables (open drain).
module mouse_transmitter #(
  parameter int unsigned T_CLK_HOLD  = 6000,
  parameter int unsigned T_SETUP     = 100,
  parameter int unsigned T_FIRST_CLK = 750000,
  parameter int unsigned T_TIMEOUT   = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT,
  output logic       DATA_MOUSE_OUT_EN,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic [2:0] state_dbg
);

  // Request handshake: SEND_BYTE is a single-cycle strobe that is accepted
  // only while BUSY=0 (state IDLE); BYTE_TO_SEND is captured in that cycle.
  // BUSY rises the next cycle and stays high until the state returns to IDLE;
  // BYTE_SENT pulses once per accepted request and BYTE_ERROR_CODE is valid
  // from that pulse until the next accepted request.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLD      = 3'd1,
    S_SEND      = 3'd2,
    S_ACK       = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [19:0] DATA_START = 20'(T_CLK_HOLD - 1);
  localparam logic [19:0] HOLD_END   = 20'(T_CLK_HOLD + T_SETUP - 1);
  localparam logic [19:0] FIRST_LIM  = 20'(T_FIRST_CLK);
  localparam logic [19:0] TO_LIM     = 20'(T_TIMEOUT);

  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  byte_q, byte_d;
  logic        parity_q, parity_d;
  logic        first_q, first_d;
  logic        clk_sync_q, clk_sync_d;
  logic        idle_q, idle_d;
  logic        clk_oe_q, clk_oe_d;
  logic        data_oe_q, data_oe_d;
  logic        data_out_q, data_out_d;
  logic        busy_q, busy_d;
  logic        sent_q, sent_d;
  logic [1:0]  err_q, err_d;

  logic        fe;
  logic [19:0] limit;
  logic        timed_out;

  assign fe        = clk_sync_q & ~CLK_MOUSE_IN;
  assign limit     = first_q ? TO_LIM : FIRST_LIM;
  assign timed_out = (cnt_q == limit);

  // Next-state, counters and registered line/status outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_d     = byte_q;
    parity_d   = parity_q;
    first_d    = first_q;
    clk_oe_d   = clk_oe_q;
    data_oe_d  = data_oe_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    clk_sync_d = CLK_MOUSE_IN;
    // Bus idle is registered so BYTE_SENT lands two cycles after idle.
    idle_d     = CLK_MOUSE_IN & DATA_MOUSE_IN;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (SEND_BYTE) begin
          byte_d   = BYTE_TO_SEND;
          parity_d = ~^BYTE_TO_SEND;
          err_d    = 2'b00;
          cnt_d    = '0;
          idx_d    = '0;
          first_d  = 1'b0;
          clk_oe_d = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        // Device falling edges are ignored while the host owns the clock.
        clk_oe_d = 1'b1;
        cnt_d    = cnt_q + 20'd1;
        if (cnt_q == DATA_START) begin
          data_oe_d  = 1'b1;
          data_out_d = 1'b0;
        end
        if (cnt_q == HOLD_END) begin
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        if (fe) begin
          cnt_d   = '0;
          first_d = 1'b1;
          if (idx_q <= 4'd8) begin
            data_out_d = idx_q[3] ? parity_q : byte_q[idx_q[2:0]];
            idx_d      = idx_q + 4'd1;
          end else begin
            data_oe_d = 1'b0;
            state_d   = S_ACK;
          end
        end else if (timed_out) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d[1]  = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_ACK: begin
        if (fe) begin
          cnt_d = '0;
          if (DATA_MOUSE_IN) err_d[0] = 1'b1;
          state_d = S_WAIT_IDLE;
        end else if (timed_out) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d[1]  = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_WAIT_IDLE: begin
        if (idle_q) begin
          state_d = S_DONE;
        end else if (timed_out) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d[1]  = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    sent_d = (state_d == S_DONE);
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      byte_q     <= '0;
      parity_q   <= 1'b0;
      first_q    <= 1'b0;
      clk_sync_q <= 1'b1;
      idle_q     <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= 1'b0;
      busy_q     <= 1'b0;
      sent_q     <= 1'b0;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      parity_q   <= parity_d;
      first_q    <= first_d;
      clk_sync_q <= clk_sync_d;
      idle_q     <= idle_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
      busy_q     <= busy_d;
      sent_q     <= sent_d;
      err_q      <= err_d;
    end
  end

  assign CLK_MOUSE_OUT_EN  = clk_oe_q;
  assign DATA_MOUSE_OUT_EN = data_oe_q;
  assign DATA_MOUSE_OUT    = data_out_q;
  assign BUSY              = busy_q;
  assign BYTE_SENT         = sent_q;
  assign BYTE_ERROR_CODE   = err_q;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_mouse_transmitter.sv
// Bench for mouse_transmitter: open-drain bus with a PS/2 device model,
// table of byte transfers plus hand-written timeout, interference and
// reset sequences.
module tb_mouse_transmitter;

  localparam int T_CLK_HOLD  = 6000;
  localparam int T_SETUP     = 100;
  localparam int T_FIRST_CLK = 1000;
  localparam int T_TIMEOUT   = 500;
  localparam int DEV_HALF    = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CLK_MOUSE_IN, DATA_MOUSE_IN;
  logic       CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT, DATA_MOUSE_OUT_EN;
  logic       SEND_BYTE = 1'b0;
  logic [7:0] BYTE_TO_SEND = 8'h00;
  logic       BUSY, BYTE_SENT;
  logic [1:0] BYTE_ERROR_CODE;
  logic [2:0] state_dbg;

  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;

  // Open-drain lines with pull-ups.
  assign CLK_MOUSE_IN  = CLK_MOUSE_OUT_EN ? 1'b0 : dev_clk;
  assign DATA_MOUSE_IN = (DATA_MOUSE_OUT_EN ? DATA_MOUSE_OUT : 1'b1) & dev_data;

  mouse_transmitter #(
    .T_CLK_HOLD(T_CLK_HOLD), .T_SETUP(T_SETUP),
    .T_FIRST_CLK(T_FIRST_CLK), .T_TIMEOUT(T_TIMEOUT)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .CLK_MOUSE_IN(CLK_MOUSE_IN), .DATA_MOUSE_IN(DATA_MOUSE_IN),
    .CLK_MOUSE_OUT_EN(CLK_MOUSE_OUT_EN), .DATA_MOUSE_OUT(DATA_MOUSE_OUT),
    .DATA_MOUSE_OUT_EN(DATA_MOUSE_OUT_EN),
    .SEND_BYTE(SEND_BYTE), .BYTE_TO_SEND(BYTE_TO_SEND),
    .BUSY(BUSY), .BYTE_SENT(BYTE_SENT), .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .state_dbg(state_dbg)
  );

  // Clock generation.
  always #5 CLK = ~CLK;

  int tests_run = 0;
  int fail_cnt = 0;
  int clk_low_cnt = 0;
  int data_low_cnt = 0;
  int sent_cnt = 0;
  logic [9:0] exp_q[$];
  logic [1:0] exp_code_q[$];
  logic [1:0] code_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests_run++;
    if (act < lo || act > hi) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: hold-phase measurements and BYTE_SENT scoreboard.
  always @(negedge CLK) begin
    if (RESET) begin
      if (CLK_MOUSE_OUT_EN) clk_low_cnt++;
      if (CLK_MOUSE_OUT_EN && DATA_MOUSE_OUT_EN && !DATA_MOUSE_OUT) data_low_cnt++;
      if (BYTE_SENT) begin
        sent_cnt++;
        if (exp_code_q.size() == 0) begin
          tests_run++;
          fail_cnt++;
          $display("FAIL byte_sent_unexpected: got pulse expected none");
        end else begin
          code_exp = exp_code_q.pop_front();
          check("error_code", 32'(BYTE_ERROR_CODE), 32'(code_exp));
        end
      end
    end
  end

  // Driver: issue one request and push its expectations.
  task automatic send(input logic [7:0] b, input bit track_frame,
                      input bit has_code, input logic [1:0] code);
    @(negedge CLK);
    check("idle_before_send", 32'(BUSY), 32'd0);
    clk_low_cnt  = 0;
    data_low_cnt = 0;
    if (track_frame) exp_q.push_back({1'b1, ~^b, b});
    if (has_code) exp_code_q.push_back(code);
    SEND_BYTE    = 1'b1;
    BYTE_TO_SEND = b;
    @(negedge CLK);
    SEND_BYTE    = 1'b0;
    BYTE_TO_SEND = 8'($urandom_range(0, 255));
    check("busy_after_accept", 32'(BUSY), 32'd1);
  endtask

  // Wait for the host to release the clock, then check hold timing.
  task automatic wait_release(output bit ok);
    int n;
    n = 0;
    while (CLK_MOUSE_OUT_EN && n < T_CLK_HOLD + T_SETUP + 50) begin
      @(negedge CLK);
      n++;
    end
    ok = !CLK_MOUSE_OUT_EN;
    check("clock_released", 32'(ok), 32'd1);
    check("clock_low_cycles", 32'(clk_low_cnt), 32'(T_CLK_HOLD + T_SETUP));
    check("data_low_cycles", 32'(data_low_cnt), 32'(T_SETUP));
    check("start_bit", 32'(DATA_MOUSE_IN), 32'd0);
  endtask

  // Device model: n_clk falling edges; samples data at the end of each low phase.
  task automatic run_device(input int n_clk, input bit ack, input bit check_frame);
    logic [9:0] got;
    logic [9:0] exp;
    got = '0;
    for (int k = 1; k <= n_clk; k++) begin
      repeat (DEV_HALF) @(negedge CLK);
      if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk = 1'b0;
      repeat (DEV_HALF) @(negedge CLK);
      if (k <= 10) got[k-1] = DATA_MOUSE_IN;
      dev_clk = 1'b1;
      if (k == 11) begin
        dev_data = 1'b1;
        @(negedge CLK);
        check("sent_not_early", 32'(BYTE_SENT), 32'd0);
        @(negedge CLK);
        check("sent_latency", 32'(BYTE_SENT), 32'd1);
      end
    end
    if (check_frame && n_clk == 11) begin
      if (exp_q.size() == 0) begin
        check("frame_expected", 32'd0, 32'd1);
      end else begin
        exp = exp_q.pop_front();
        check("frame_bits", 32'(got), 32'(exp));
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (BUSY && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check("busy_cleared", 32'(BUSY), 32'd0);
  endtask

  typedef struct {
    logic [7:0] b;
    bit         ack;
    logic [1:0] code;
  } vec_t;

  vec_t tbl[4];

  initial begin
    bit ok;
    int n;
    int s;

    tbl[0] = '{8'hF4, 1'b1, 2'b00};
    tbl[1] = '{8'hFF, 1'b0, 2'b01};
    tbl[2] = '{8'h00, 1'b1, 2'b00};
    tbl[3] = '{8'($urandom_range(1, 254)), 1'b1, 2'b00};

    // Reset state.
    repeat (3) @(negedge CLK);
    check("rst_clk_oe", 32'(CLK_MOUSE_OUT_EN), 32'd0);
    check("rst_data_oe", 32'(DATA_MOUSE_OUT_EN), 32'd0);
    check("rst_data_out", 32'(DATA_MOUSE_OUT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_sent", 32'(BYTE_SENT), 32'd0);
    check("rst_code", 32'(BYTE_ERROR_CODE), 32'd0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Table of complete transfers.
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].b, 1'b1, 1'b1, tbl[i].code);
      wait_release(ok);
      if (ok) run_device(11, tbl[i].ack, 1'b1);
      wait_idle();
      check("code_held", 32'(BYTE_ERROR_CODE), 32'(tbl[i].code));
    end

    // Requests during a transfer are dropped; frame still carries 0xF4.
    send(8'hF4, 1'b1, 1'b1, 2'b00);
    fork
      begin
        bit ok2;
        wait_release(ok2);
        if (ok2) run_device(11, 1'b1, 1'b1);
      end
      begin
        repeat (50) @(negedge CLK);
        check("busy_in_hold", 32'(BUSY), 32'd1);
        SEND_BYTE = 1'b1; BYTE_TO_SEND = 8'h00;
        @(negedge CLK);
        SEND_BYTE = 1'b0;
        repeat (6150) @(negedge CLK);
        check("busy_in_send", 32'(BUSY), 32'd1);
        SEND_BYTE = 1'b1; BYTE_TO_SEND = 8'h00;
        @(negedge CLK);
        SEND_BYTE = 1'b0;
      end
    join
    wait_idle();

    // Device never clocks after release.
    send(8'hF4, 1'b0, 1'b1, 2'b10);
    wait_release(ok);
    n = 0;
    while (DATA_MOUSE_OUT_EN && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check_range("first_clk_timeout", n, T_FIRST_CLK, T_FIRST_CLK + 1);
    check("sent_with_release", 32'(BYTE_SENT), 32'd1);
    check("clk_released_on_timeout", 32'(CLK_MOUSE_OUT_EN), 32'd0);
    wait_idle();

    // Device stops after bit 3, then a clean 0xF4.
    send(8'hF4, 1'b0, 1'b1, 2'b10);
    wait_release(ok);
    if (ok) run_device(4, 1'b1, 1'b0);
    wait_idle();
    check("timeout_code_held", 32'(BYTE_ERROR_CODE), 32'd2);
    check("lines_released", 32'({CLK_MOUSE_OUT_EN, DATA_MOUSE_OUT_EN}), 32'd0);
    send(8'hF4, 1'b1, 1'b1, 2'b00);
    wait_release(ok);
    if (ok) run_device(11, 1'b1, 1'b1);
    wait_idle();

    // Reset during SEND at index 5.
    send(8'h5A, 1'b0, 1'b0, 2'b00);
    wait_release(ok);
    if (ok) run_device(5, 1'b1, 1'b0);
    check("busy_before_reset", 32'(BUSY), 32'd1);
    check("data_oe_before_reset", 32'(DATA_MOUSE_OUT_EN), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("reset_clk_oe", 32'(CLK_MOUSE_OUT_EN), 32'd0);
    check("reset_data_oe", 32'(DATA_MOUSE_OUT_EN), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    s = sent_cnt;
    repeat (100) @(negedge CLK);
    check("no_sent_after_reset", 32'(sent_cnt), 32'(s));
    check("idle_after_reset", 32'(BUSY), 32'd0);

    check("frames_left", 32'(exp_q.size()), 32'd0);
    check("codes_left", 32'(exp_code_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
